// File: rtl/mc_main_ctrl_if.sv
// ============================================================================
// Module      : mc_main_ctrl_if
// Description : Bundle between the multicycle main controller and the rest of
//               the datapath. Carries the opcode, the ALU zero flag and the
//               memory-ready handshake into the controller, and every mux
//               select, write enable, aluop and status pulse back out.
// Modports    : master - controller side (drives controls, reads op/flags)
//               slave  - datapath side  (drives op/flags, reads controls)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_main_ctrl_if;
  // datapath -> controller
  logic [5:0] op;          // instr[31:26], valid from DECODE onward
  logic       zero;        // ALU zero flag (branch resolution is external)
  logic       mem_ready;   // memory access completes this cycle

  // controller -> datapath
  logic       memtoreg;
  logic       regdst;
  logic       iord;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       irwrite;
  logic       memwrite;
  logic       pcwrite;
  logic       branch;
  logic       branchne;
  logic       regwrite;
  logic [1:0] aluop;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
           memwrite, pcwrite, branch, branchne, regwrite, aluop,
           illegal_op, mem_err, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
           memwrite, pcwrite, branch, branchne, regwrite, aluop,
           illegal_op, mem_err, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_main_ctrl.sv
// ============================================================================
// Module      : mc_main_ctrl
// Description : Multicycle main controller FSM. Steps each instruction through
//               fetch / decode / execute / memory / writeback, drives datapath
//               selects and enables plus the 2-bit aluop for aludec, waits on a
//               memory-ready handshake with optional timeout, and flags
//               unsupported opcodes.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high
//               bus   - mc_main_ctrl_if.master (op/zero/mem_ready in, all
//                       controls, illegal_op, mem_err and debug state out)
// Parameters  : TIMEOUT_CYCLES - consecutive mem_ready-low cycles in a wait
//               state before abort; 0 removes the counter (wait forever)
// Options     : MC_BNE_EN - when defined, op 000101 decodes to a BNE state
//               driving branchne; otherwise that op is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          reset,
  mc_main_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_wait;
  logic       w_timeout;
  logic       w_en;

  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_iord;
  logic [1:0] w_pcsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_pcwrite;
  logic       w_branch;
`ifdef MC_BNE_EN
  logic       w_branchne;
`endif
  logic       w_regwrite;
  logic [1:0] w_aluop;
  logic       w_illegal;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                  (r_state == S_MEMWR);

  // --------------------------------------------------------------------------
  // Memory timeout. The counter only ever leaves zero while stalled in a wait
  // state, and every exit from a wait state happens on mem_ready or timeout,
  // both of which clear it -- so each wait state is entered with a zero count.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] r_cnt;

      assign w_timeout = w_wait && !bus.mem_ready &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_wait && !bus.mem_ready && !w_timeout) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_iord     = 1'b0;
    w_pcsrc    = 2'b00;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
`ifdef MC_BNE_EN
    w_branchne = 1'b0;
`endif
    w_regwrite = 1'b0;
    w_aluop    = 2'b00;
    w_illegal  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = S_BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        w_alusrca  = 1'b1;
        w_aluop    = 2'b01;
        w_pcsrc    = 2'b01;
        w_branchne = 1'b1;
        w_next     = S_FETCH;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase

    // An expired wait abandons the instruction; a same-cycle mem_ready has
    // already suppressed w_timeout, so ready wins.
    if (w_timeout) begin
      w_next = S_FETCH;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Enables are suppressed in reset and in a timeout cycle so an
  // aborted instruction never issues a write.
  // --------------------------------------------------------------------------
  assign w_en = !reset && !w_timeout;

  assign bus.memtoreg   = w_memtoreg;
  assign bus.regdst     = w_regdst;
  assign bus.iord       = w_iord;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.aluop      = w_aluop;
  assign bus.irwrite    = w_irwrite  & w_en;
  assign bus.memwrite   = w_memwrite & w_en;
  assign bus.pcwrite    = w_pcwrite  & w_en;
  assign bus.branch     = w_branch   & w_en;
  assign bus.regwrite   = w_regwrite & w_en;
  assign bus.illegal_op = w_illegal  & !reset;
  assign bus.mem_err    = w_timeout  & !reset;
  assign bus.state      = r_state;
`ifdef MC_BNE_EN
  assign bus.branchne   = w_branchne & w_en;
`else
  assign bus.branchne   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
// ============================================================================
// Module      : tb_mc_main_ctrl
// Description : Directed self-checking bench for mc_main_ctrl. Each task walks
//               one instruction class or scenario cycle by cycle and compares
//               the packed controller outputs with hand-derived vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mc_main_ctrl_if bus ();

  mc_main_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite, memwrite,
  //  pcwrite, branch, branchne, regwrite, aluop, illegal_op, mem_err, state}
  logic [21:0] obs;
  assign obs = {bus.memtoreg, bus.regdst, bus.iord, bus.pcsrc, bus.alusrca,
                bus.alusrcb, bus.irwrite, bus.memwrite, bus.pcwrite, bus.branch,
                bus.branchne, bus.regwrite, bus.aluop, bus.illegal_op,
                bus.mem_err, bus.state};

  //                                 mtr  rd   iord pcsrc asa  asb   irw  mw   pcw  br   brne rw   aluop ill  merr st
  localparam logic [21:0] E_FETCH_WAIT = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd0};
  localparam logic [21:0] E_FETCH_RDY  = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd0};
  localparam logic [21:0] E_FETCH_ERR  = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,4'd0};
  localparam logic [21:0] E_DECODE     = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd1};
  localparam logic [21:0] E_DECODE_ILL = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,4'd1};
  localparam logic [21:0] E_MEMADR     = {1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd2};
  localparam logic [21:0] E_MEMRD      = {1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd3};
  localparam logic [21:0] E_MEMRD_ERR  = {1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,4'd3};
  localparam logic [21:0] E_MEMWB      = {1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,4'd4};
  localparam logic [21:0] E_MEMWR      = {1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd5};
  localparam logic [21:0] E_EXEC       = {1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,4'd6};
  localparam logic [21:0] E_ALUWB      = {1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,4'd7};
  localparam logic [21:0] E_BEQ        = {1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,4'd8};
  localparam logic [21:0] E_ADDIEX     = {1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd9};
  localparam logic [21:0] E_ADDIWB     = {1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,4'd10};
  localparam logic [21:0] E_JUMP       = {1'b0,1'b0,1'b0,2'b10,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,4'd11};
  localparam logic [21:0] E_BNE        = {1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,1'b0,4'd12};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One reset cycle so every scenario starts from FETCH with a clear counter.
  task automatic go_idle;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    #1; checks++;
    if (obs !== E_FETCH_WAIT) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, E_FETCH_WAIT); end
    bus.mem_ready = 1'b1;
    #1; checks++;
    if (obs !== E_FETCH_WAIT) begin errors++; $display("FAIL reset_gates_enables: got %h expected %h", obs, E_FETCH_WAIT); end
    reset = 1'b0;
    bus.op = 6'b000000;
    #1; checks++;
    if (obs !== E_FETCH_RDY) begin errors++; $display("FAIL reset_rel_fetch: got %h expected %h", obs, E_FETCH_RDY); end
    cyc();
    #1; checks++;
    if (obs !== E_DECODE) begin errors++; $display("FAIL reset_rel_decode: got %h expected %h", obs, E_DECODE); end
    cyc();
    #1; checks++;
    if (obs !== E_EXEC) begin errors++; $display("FAIL reset_rel_exec: got %h expected %h", obs, E_EXEC); end
    // Reset held three cycles starting mid-EXECUTE: no register write, FETCH after.
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      #1; checks++;
      if ({bus.regwrite, bus.state} !== {1'b0, (i == 0) ? 4'd6 : 4'd0}) begin
        errors++;
        $display("FAIL reset_mid_exec cycle %0d: got regwrite/state %h expected %h", i,
                 {bus.regwrite, bus.state}, {1'b0, (i == 0) ? 4'd6 : 4'd0});
      end
      cyc();
    end
    reset = 1'b0;
    #1; checks++;
    if (obs !== E_FETCH_RDY) begin errors++; $display("FAIL post_reset_fetch: got %h expected %h", obs, E_FETCH_RDY); end
  endtask

  task automatic test_lw;
    logic [21:0] ev [6];
    ev = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH_RDY};
    go_idle();
    bus.op = 6'b100011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL lw cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
  endtask

  task automatic test_rtype;
    logic [21:0] ev [5];
    ev = '{E_FETCH_RDY, E_DECODE, E_EXEC, E_ALUWB, E_FETCH_RDY};
    go_idle();
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL rtype cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
  endtask

  task automatic test_addi;
    logic [21:0] ev [5];
    ev = '{E_FETCH_RDY, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH_RDY};
    go_idle();
    bus.op = 6'b001000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL addi cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
  endtask

  task automatic test_beq_jump;
    logic [21:0] ev [4];
    ev = '{E_FETCH_RDY, E_DECODE, E_BEQ, E_FETCH_RDY};
    go_idle();
    bus.op = 6'b000100;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL beq cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
    ev = '{E_FETCH_RDY, E_DECODE, E_JUMP, E_FETCH_RDY};
    go_idle();
    bus.op = 6'b000010;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL jump cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
  endtask

  task automatic test_sw_wait;
    go_idle();
    bus.op = 6'b101011;
    bus.mem_ready = 1'b1;
    #1; checks++;
    if (obs !== E_FETCH_RDY) begin errors++; $display("FAIL sw fetch: got %h expected %h", obs, E_FETCH_RDY); end
    cyc();
    #1; checks++;
    if (obs !== E_DECODE) begin errors++; $display("FAIL sw decode: got %h expected %h", obs, E_DECODE); end
    cyc();
    #1; checks++;
    if (obs !== E_MEMADR) begin errors++; $display("FAIL sw memadr: got %h expected %h", obs, E_MEMADR); end
    cyc();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== E_MEMWR) begin errors++; $display("FAIL sw memwr wait %0d: got %h expected %h", i, obs, E_MEMWR); end
      cyc();
    end
    bus.mem_ready = 1'b1;
    #1; checks++;
    if (obs !== E_MEMWR) begin errors++; $display("FAIL sw memwr ready: got %h expected %h", obs, E_MEMWR); end
    cyc();
    #1; checks++;
    if (obs !== E_FETCH_RDY) begin errors++; $display("FAIL sw exit: got %h expected %h", obs, E_FETCH_RDY); end
  endtask

  task automatic test_fetch_timeout;
    logic [21:0] e;
    go_idle();
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      e = (i == 15) ? E_FETCH_ERR : E_FETCH_WAIT;
      #1; checks++;
      if (obs !== e) begin errors++; $display("FAIL fetch_timeout cycle %0d: got %h expected %h", i, obs, e); end
      cyc();
    end
    // Counter restarts after the abort; ready on the 15th cycle beats timeout.
    for (int i = 1; i <= 14; i++) begin
      #1; checks++;
      if (obs !== E_FETCH_WAIT) begin errors++; $display("FAIL fetch_rewait cycle %0d: got %h expected %h", i, obs, E_FETCH_WAIT); end
      cyc();
    end
    bus.mem_ready = 1'b1;
    bus.op = 6'b000000;
    #1; checks++;
    if (obs !== E_FETCH_RDY) begin errors++; $display("FAIL fetch_ready_wins: got %h expected %h", obs, E_FETCH_RDY); end
    cyc();
    #1; checks++;
    if (obs !== E_DECODE) begin errors++; $display("FAIL fetch_ready_wins next: got %h expected %h", obs, E_DECODE); end
  endtask

  task automatic test_memrd_timeout;
    logic [21:0] e;
    go_idle();
    bus.op = 6'b100011;
    bus.mem_ready = 1'b1;
    cyc();
    cyc();
    #1; checks++;
    if (obs !== E_MEMADR) begin errors++; $display("FAIL memrd_to memadr: got %h expected %h", obs, E_MEMADR); end
    cyc();
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      e = (i == 15) ? E_MEMRD_ERR : E_MEMRD;
      #1; checks++;
      if (obs !== e) begin errors++; $display("FAIL memrd_timeout cycle %0d: got %h expected %h", i, obs, e); end
      cyc();
    end
    #1; checks++;
    if (obs !== E_FETCH_WAIT) begin errors++; $display("FAIL memrd_timeout exit: got %h expected %h", obs, E_FETCH_WAIT); end
  endtask

  task automatic test_illegal_bne;
    logic [21:0] ev [4];
    ev = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_RDY, E_DECODE};
    go_idle();
    bus.op = 6'b111111;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
`ifdef MC_BNE_EN
    ev = '{E_FETCH_RDY, E_DECODE, E_BNE, E_FETCH_RDY};
`else
    ev = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_RDY, E_DECODE_ILL};
`endif
    go_idle();
    bus.op = 6'b000101;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== ev[i]) begin errors++; $display("FAIL bne cycle %0d: got %h expected %h", i, obs, ev[i]); end
      cyc();
    end
  endtask

  initial begin
    bus.op        = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_addi();
    test_beq_jump();
    test_sw_wait();
    test_fetch_timeout();
    test_memrd_timeout();
    test_illegal_bne();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
